// File: rtl/spi_slave_char_trx.sv
// rtl/spi_slave_char_trx.sv - SPI slave character transceiver with oversampled SCK/CS/MOSI
module spi_slave_char_trx #(
    parameter int CHAR_NBITS = 32
) (
    input  logic                  S_SYSCLK,
    input  logic                  S_RESETN,
    input  logic                  S_ENABLE,
    input  logic                  S_CPOL,
    input  logic                  S_CPHA,
    input  logic                  S_REV,
    input  logic [3:0]            S_CHAR_LEN,
    input  logic                  S_SPI_CS,
    input  logic                  S_SPI_SCK,
    output logic                  S_SPI_MISO,
    input  logic                  S_SPI_MOSI,
    output logic                  S_CHAR_DONE,
    input  logic [CHAR_NBITS-1:0] S_WCHAR,
    output logic [CHAR_NBITS-1:0] S_RCHAR
);

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    state_t      state, state_nxt;
    logic        sck_s1, sck_s2, sck_s3;
    logic        cs_s1, cs_s2;
    logic        mosi_s1, mosi_s2;
    logic        cpha_l, rev_l;
    logic [3:0]  len_m1;
    logic [3:0]  bit_cnt;
    logic [15:0] tx_sr, rx_sr, rx_upd;
    logic        miso_en, skip_adv;
    logic        active, lead_edge, trail_edge;
    logic        start, smp, adv, last_bit, tx_bit;
    logic        unused_wchar;

    // Only the low 16 bits of the transmit word can ever be sent.
    assign unused_wchar = ^S_WCHAR[CHAR_NBITS-1:16];

    // Place the transmit word so the first bit sits at the shifted-out end of the register.
    function automatic logic [15:0] tx_load(input logic [15:0] w, input logic r, input logic [3:0] lm1);
        return r ? (w << (4'd15 - lm1)) : w;
    endfunction

    assign active     = S_ENABLE && !cs_s2;
    assign lead_edge  = (sck_s3 == S_CPOL) && (sck_s2 != S_CPOL);
    assign trail_edge = (sck_s3 != S_CPOL) && (sck_s2 == S_CPOL);
    assign tx_bit     = rev_l ? tx_sr[15] : tx_sr[0];
    assign last_bit   = smp && (bit_cnt == len_m1);
    assign S_SPI_MISO = (miso_en && active && state == ST_XFER) ? tx_bit : 1'bz;

    // Two-flop synchronizers, plus a third SCK stage for edge detection.
    always_ff @(posedge S_SYSCLK) begin
        if (!S_RESETN) begin
            sck_s1  <= S_CPOL;
            sck_s2  <= S_CPOL;
            sck_s3  <= S_CPOL;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= S_SPI_SCK;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= S_SPI_CS;
            cs_s2   <= cs_s1;
            mosi_s1 <= S_SPI_MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    // State register.
    always_ff @(posedge S_SYSCLK) begin
        if (!S_RESETN) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Next state, character start, and which SCK edge samples or advances in this mode.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        smp       = 1'b0;
        adv       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (active) begin
                    state_nxt = ST_XFER;
                    start     = 1'b1;
                end
            end
            ST_XFER: begin
                if (!active) begin
                    state_nxt = ST_IDLE;
                end else begin
                    smp = cpha_l ? trail_edge : lead_edge;
                    adv = cpha_l ? lead_edge : trail_edge;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Receive word with the current MOSI bit merged in.
    always_comb begin
        rx_upd = rx_sr;
        if (rev_l) rx_upd = {rx_sr[14:0], mosi_s2};
        else       rx_upd[bit_cnt] = mosi_s2;
    end

    // Shift datapath: load at start, sample/advance on SCK edges, re-arm after the last bit.
    always_ff @(posedge S_SYSCLK) begin
        if (!S_RESETN) begin
            cpha_l      <= 1'b0;
            rev_l       <= 1'b0;
            len_m1      <= 4'd0;
            bit_cnt     <= 4'd0;
            tx_sr       <= 16'd0;
            rx_sr       <= 16'd0;
            miso_en     <= 1'b0;
            skip_adv    <= 1'b0;
            S_CHAR_DONE <= 1'b0;
            S_RCHAR     <= '0;
        end else begin
            S_CHAR_DONE <= 1'b0;
            if (start) begin
                cpha_l   <= S_CPHA;
                rev_l    <= S_REV;
                len_m1   <= S_CHAR_LEN;
                tx_sr    <= tx_load(S_WCHAR[15:0], S_REV, S_CHAR_LEN);
                rx_sr    <= 16'd0;
                bit_cnt  <= 4'd0;
                // CPHA=0 presents bit 0 immediately; CPHA=1 waits for the first leading edge.
                miso_en  <= !S_CPHA;
                skip_adv <= S_CPHA;
            end else if (state == ST_XFER && !active) begin
                bit_cnt  <= 4'd0;
                miso_en  <= 1'b0;
                skip_adv <= 1'b0;
            end else if (state == ST_XFER) begin
                if (smp) begin
                    if (last_bit) begin
                        S_RCHAR     <= {{(CHAR_NBITS-16){1'b0}}, rx_upd};
                        S_CHAR_DONE <= 1'b1;
                        bit_cnt     <= 4'd0;
                        rx_sr       <= 16'd0;
                        tx_sr       <= tx_load(S_WCHAR[15:0], rev_l, len_m1);
                        // The reloaded first bit must survive the next advance edge.
                        skip_adv    <= 1'b1;
                    end else begin
                        rx_sr   <= rx_upd;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                if (adv) begin
                    if (skip_adv) begin
                        skip_adv <= 1'b0;
                        miso_en  <= 1'b1;
                    end else begin
                        tx_sr <= rev_l ? (tx_sr << 1) : (tx_sr >> 1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_char_trx.sv
// tb/tb_spi_slave_char_trx.sv - directed scoreboard bench for spi_slave_char_trx
module tb_spi_slave_char_trx;
    localparam int CHAR_NBITS = 32;
    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        resetn, enable, cpol, cpha, rev;
    logic [3:0]  char_len;
    logic        cs, sck, mosi;
    wire         miso;
    logic        done;
    logic [31:0] wchar, rchar;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [31:0] exp_q[$];

    pullup (miso);

    always #5 clk = ~clk;

    spi_slave_char_trx #(.CHAR_NBITS(CHAR_NBITS)) dut (
        .S_SYSCLK(clk),
        .S_RESETN(resetn),
        .S_ENABLE(enable),
        .S_CPOL(cpol),
        .S_CPHA(cpha),
        .S_REV(rev),
        .S_CHAR_LEN(char_len),
        .S_SPI_CS(cs),
        .S_SPI_SCK(sck),
        .S_SPI_MISO(miso),
        .S_SPI_MOSI(mosi),
        .S_CHAR_DONE(done),
        .S_WCHAR(wchar),
        .S_RCHAR(rchar)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_done observed=1 expected=0");
            end
            if (exp_q.size() != 0) check("rchar_at_done", rchar, exp_q.pop_front());
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input int nbits, input int send_bits, input logic [15:0] tx,
                        input logic [15:0] exp_miso, input string tag);
        int idx;
        for (int i = 0; i < send_bits; i++) begin
            idx = rev ? (nbits - 1 - i) : i;
            if (!cpha) begin
                mosi = tx[idx];
                wait_clk(HALF);
                check($sformatf("%s_miso%0d", tag, i), {31'd0, miso}, {31'd0, exp_miso[idx]});
                sck = ~cpol;
                wait_clk(HALF);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = tx[idx];
                wait_clk(HALF);
                check($sformatf("%s_miso%0d", tag, i), {31'd0, miso}, {31'd0, exp_miso[idx]});
                sck = cpol;
                wait_clk(HALF);
            end
        end
    endtask

    task automatic send_char(input int nbits, input logic [15:0] tx, input logic [15:0] exp_miso, input string tag);
        logic [31:0] mask;
        mask = (32'd1 << nbits) - 32'd1;
        exp_q.push_back({16'd0, tx} & mask);
        exp_done++;
        xfer(nbits, nbits, tx, exp_miso, tag);
    endtask

    initial begin
        logic [7:0] seq [6];
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h44, 8'h33};

        resetn = 1'b0; enable = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b1; rev = 1'b1; char_len = 4'd7; wchar = 32'h1faa1234;
        wait_clk(3);
        resetn = 1'b1;
        wait_clk(1);
        check("reset_rchar", rchar, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_miso_z", {31'd0, miso}, 32'd1);
        wait_clk(20);
        check("idle_done_cnt", done_cnt, 0);

        // single 8-bit character, CPOL=0 CPHA=1 MSB first
        cs = 1'b0; wait_clk(HALF);
        send_char(8, 16'h0001, 16'h0034, "single");
        wait_clk(HALF); cs = 1'b1; wait_clk(10);
        check("single_done_cnt", done_cnt, exp_done);
        check("single_rchar", rchar, 32'h1);
        check("single_miso_z", {31'd0, miso}, 32'd1);

        // six back-to-back characters under one CS
        cs = 1'b0; wait_clk(HALF);
        for (int k = 0; k < 6; k++) send_char(8, {8'd0, seq[k]}, 16'h0034, $sformatf("b2b%0d", k));
        wait_clk(HALF); cs = 1'b1; wait_clk(10);
        check("b2b_done_cnt", done_cnt, exp_done);
        check("b2b_rchar", rchar, 32'h33);

        // 16-bit, CPOL=1 CPHA=0 LSB first
        cpol = 1'b1; sck = 1'b1; cpha = 1'b0; rev = 1'b0; char_len = 4'd15; wchar = 32'h0000A5C3;
        wait_clk(8);
        cs = 1'b0; wait_clk(HALF);
        send_char(16, 16'h8001, 16'hA5C3, "w16");
        wait_clk(HALF); cs = 1'b1; wait_clk(10);
        check("w16_done_cnt", done_cnt, exp_done);
        check("w16_rchar", rchar, 32'h8001);

        // abort after 4 bits, then a full character
        cpol = 1'b0; sck = 1'b0; cpha = 1'b1; rev = 1'b1; char_len = 4'd7; wchar = 32'h0;
        wait_clk(8);
        cs = 1'b0; wait_clk(HALF);
        xfer(8, 4, 16'h00F0, 16'h0000, "abort");
        cs = 1'b1; wait_clk(10);
        check("abort_done_cnt", done_cnt, exp_done);
        check("abort_rchar", rchar, 32'h8001);
        check("abort_miso_z", {31'd0, miso}, 32'd1);
        wchar = 32'h34;
        cs = 1'b0; wait_clk(HALF);
        send_char(8, 16'h005A, 16'h0034, "after_abort");
        wait_clk(HALF); cs = 1'b1; wait_clk(10);
        check("after_abort_rchar", rchar, 32'h5A);

        // disabled: SCK toggles with CS low but nothing happens
        enable = 1'b0;
        cs = 1'b0; wait_clk(HALF);
        xfer(8, 8, 16'h00C3, 16'hFFFF, "disabled");
        wait_clk(HALF); cs = 1'b1; enable = 1'b1; wait_clk(10);
        check("disabled_done_cnt", done_cnt, exp_done);
        check("disabled_rchar", rchar, 32'h5A);

        // synchronous reset in the middle of a character
        cs = 1'b0; wait_clk(HALF);
        xfer(8, 4, 16'h00FF, 16'h0034, "mid_reset");
        resetn = 1'b0; wait_clk(2);
        check("mid_reset_rchar", rchar, 32'd0);
        check("mid_reset_miso_z", {31'd0, miso}, 32'd1);
        cs = 1'b1; wait_clk(2);
        resetn = 1'b1; wait_clk(10);
        check("final_done_cnt", done_cnt, exp_done);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_char_trx.md
Name: spi_slave_char_trx

Overview:
- SPI slave character transceiver, used as the link-partner model and as a peripheral-side block for the eSPI-style master (spi_intface).
- Oversamples SCK, CS and MOSI in the system clock domain.
- Shifts one character of S_CHAR_LEN+1 bits out on MISO from a parallel word, and assembles the MOSI bits into a parallel word.
- Pulses a done strobe per completed character; supports CPOL/CPHA modes and MSB/LSB-first order.

Parameters:
- CHAR_NBITS, 32, width of S_WCHAR/S_RCHAR. Must be ≥16.

Ports:
- S_SYSCLK  input  1  system clock; all logic on rising edge.
- S_RESETN  input  1  synchronous, active-low reset.
- S_ENABLE  input  1  block enable; 0 = idle and flush.
- S_CPOL  input  1  SCK idle level.
- S_CPHA  input  1  0 = sample on leading SCK edge; 1 = sample on trailing SCK edge.
- S_REV  input  1  1 = MSB first; 0 = LSB first.
- S_CHAR_LEN  input  4  character length minus one (0..15 → 1..16 bits).
- S_SPI_CS  input  1  active-low chip select.
- S_SPI_SCK  input  1  serial clock from master.
- S_SPI_MISO  output  1  serial data to master; high-Z when not driving.
- S_SPI_MOSI  input  1  serial data from master.
- S_CHAR_DONE  output  1  one-cycle pulse when a character completes.
- S_WCHAR  input  CHAR_NBITS  character to transmit; bits [len-1:0] are used.
- S_RCHAR  output  CHAR_NBITS  last received character, right-aligned, upper bits zero.

Behaviour:
- Reset (S_RESETN=0 at a clock edge): S_RCHAR=0, S_CHAR_DONE=0, bit counter=0, shift registers=0, MISO high-Z, synchronizers load idle values (CS=1, SCK=S_CPOL).
- Input synchronisation:
  - SCK, CS and MOSI pass through 2-flop synchronizers; a third SCK stage provides edge detect.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Requirement: SCK high and low phases each ≥3 S_SYSCLK periods.
- Active condition: S_ENABLE=1 and synchronized CS=0.
  - When inactive: bit counter=0, no done pulse, S_RCHAR holds, MISO high-Z.
- Character start (CS falling while enabled, or re-arm after the previous character's last bit):
  - Latch S_WCHAR into the TX shift register; len = S_CHAR_LEN+1.
  - The first TX bit is WCHAR[len-1] if REV=1, else WCHAR[0].
- CPHA=0:
  - First bit is driven on MISO within 3 clocks after CS falls.
  - Sample MOSI on leading edges; advance MISO to the next bit on trailing edges.
- CPHA=1:
  - MISO is driven with the first bit on the first leading edge, and advances on each subsequent leading edge.
  - Sample MOSI on trailing edges.
- Receive assembly:
  - REV=1: shift left, new bit into LSB.
  - REV=0: place the bit at index = bit count.
  - Result is right-aligned in [len-1:0]; bits above len-1 are 0.
- Completion: on the sample of bit len-1:
  - S_RCHAR is updated with the full character on the next S_SYSCLK edge.
  - S_CHAR_DONE is high for exactly that one cycle.
  - The bit counter wraps to 0 and S_WCHAR is re-latched for the next character while CS stays low (back-to-back characters).
- CS deassert mid-character: abort. Counter → 0, no done pulse, S_RCHAR unchanged, MISO high-Z within 3 clocks.
- S_ENABLE dropping mid-character: same as CS deassert.
- S_CPOL/S_CPHA/S_REV/S_CHAR_LEN changes are permitted only while CS is high; they are sampled at character start.
- Done latency: ≤4 S_SYSCLK cycles after the raw SCK sampling edge of the last bit.

Test Plan:
- Reset then idle (S_ENABLE=1, CS=1) → S_RCHAR=0, S_CHAR_DONE never asserts, MISO=Z.
- CPOL=0, CPHA=1, REV=1, LEN=7, WCHAR=0x1faa1234; master sends 0x01 with SCK=sysclk/10 → MISO bits 0,0,1,1,0,1,0,0 (0x34); single done pulse; S_RCHAR=0x00000001.
- Same config, CS held low for 6 back-to-back characters 0x01,0x02,0x03,0x04,0x44,0x33 → 6 done pulses; S_RCHAR after each equals that byte; MISO sends 0x34 each character.
- CPOL=1, CPHA=0, REV=0, LEN=15, WCHAR=0x0000A5C3; master sends 0x8001 → MISO LSB first 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; S_RCHAR=0x00008001.
- LEN=7, CS raised after 4 bits → no done pulse, S_RCHAR unchanged; the next full character is received correctly.
- S_ENABLE=0 while CS is low and SCK toggles → no done pulse, MISO=Z; a synchronous reset mid-character clears S_RCHAR to 0.
